// File: rtl/mux_bus_slave.sv
// mux_bus_slave: memory/IO slave for a multiplexed AD/A bus.
// The address is latched under ALE and decoded against an aligned window.
// READY is held low for WAIT_STATES cycles, then one word of the internal
// array is read or written.
// Optional build macro: ACCESS_CNT_EN adds 16-bit RD_CNT/WR_CNT outputs.
module mux_bus_slave #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 20,
  parameter int                MEM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                IO_SPACE    = 0,
  parameter int                WAIT_STATES = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ALE,
  input  logic                     IOM,
  input  logic                     RD,
  input  logic                     WR,
  input  logic [DATA_W-1:0]        AD_IN,
  input  logic [ADDR_W-DATA_W-1:0] A_IN,
  output logic [DATA_W-1:0]        AD_OUT,
  output logic                     AD_OE,
  output logic                     READY,
  output logic                     CS,
  output logic                     ERR
`ifdef ACCESS_CNT_EN
  ,
  output logic [15:0]              RD_CNT,
  output logic [15:0]              WR_CNT
`endif
);

  localparam int       LP_OFF_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] LP_WS  = 4'(WAIT_STATES);
  localparam logic     LP_IO    = (IO_SPACE != 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_END} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_lat;
  logic                r_iom, w_iom_lat;
  logic [3:0]          r_wait_cnt, w_wait_cnt_next;
  logic                r_is_read, w_is_read_next;
  logic                r_ready, w_ready_next;
  logic                r_ad_oe, w_ad_oe_next;
  logic                r_cs, w_cs_next;
  logic                r_err, w_err_next;
  logic                w_latch_en, w_hit, w_both, w_one;
  logic                w_mem_we, w_mem_re;
  logic [LP_OFF_W-1:0] w_offset;
  logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
  logic [DATA_W-1:0]   r_rd_data;

  // ALE is only honoured while idle; otherwise the latched address holds.
  assign w_latch_en = (r_state == S_IDLE) && ALE;
  assign w_addr_lat = w_latch_en ? {A_IN, AD_IN} : r_addr;
  assign w_iom_lat  = w_latch_en ? IOM : r_iom;
  // The window is aligned to MEM_DEPTH, so matching the high bits is the range check.
  assign w_hit      = (w_iom_lat == LP_IO) &&
                      (w_addr_lat[ADDR_W-1:LP_OFF_W] == BASE_ADDR[ADDR_W-1:LP_OFF_W]);
  assign w_offset   = r_addr[LP_OFF_W-1:0];
  assign w_both     = !RD && !WR;
  assign w_one      = RD ^ WR;

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and next-output logic; a double strobe aborts from any state.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_is_read_next  = r_is_read;
    w_ready_next    = r_ready;
    w_ad_oe_next    = r_ad_oe;
    w_cs_next       = r_cs;
    w_err_next      = r_err;
    w_mem_we        = 1'b0;
    w_mem_re        = 1'b0;
    if (w_latch_en) w_cs_next = w_hit;
    if (w_both) begin
      w_state_next = S_IDLE;
      w_ready_next = 1'b1;
      w_ad_oe_next = 1'b0;
      w_cs_next    = 1'b0;
      w_err_next   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_one && r_cs) begin
            w_is_read_next  = !RD;
            w_wait_cnt_next = LP_WS;
            if (LP_WS == 4'd0) begin
              w_state_next = S_ACCESS;
            end else begin
              w_state_next = S_WAIT;
              w_ready_next = 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_one && ((!RD) == r_is_read)) begin
            w_wait_cnt_next = r_wait_cnt - 4'd1;
            if (r_wait_cnt <= 4'd1) begin
              w_state_next = S_ACCESS;
              w_ready_next = 1'b1;
            end
          end else begin
            // Strobe withdrawn before the access: abandon the cycle.
            w_state_next = S_IDLE;
            w_ready_next = 1'b1;
            w_cs_next    = 1'b0;
            w_err_next   = 1'b1;
          end
        end
        S_ACCESS: begin
          w_state_next = S_END;
          w_ready_next = 1'b1;
          if (r_is_read) begin
            w_mem_re     = 1'b1;
            w_ad_oe_next = 1'b1;
          end else begin
            w_mem_we = 1'b1;
          end
        end
        S_END: begin
          if (RD && WR) begin
            w_state_next = S_IDLE;
            w_ad_oe_next = 1'b0;
            w_cs_next    = 1'b0;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Bus-facing registers and the address latch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_addr     <= '0;
      r_iom      <= 1'b0;
      r_wait_cnt <= 4'd0;
      r_is_read  <= 1'b0;
      r_ready    <= 1'b1;
      r_ad_oe    <= 1'b0;
      r_cs       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_addr     <= w_addr_lat;
      r_iom      <= w_iom_lat;
      r_wait_cnt <= w_wait_cnt_next;
      r_is_read  <= w_is_read_next;
      r_ready    <= w_ready_next;
      r_ad_oe    <= w_ad_oe_next;
      r_cs       <= w_cs_next;
      r_err      <= w_err_next;
    end
  end

  // Storage array with registered read; not reset so it maps to block RAM.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[w_offset] <= AD_IN;
    if (w_mem_re) r_rd_data <= r_mem[w_offset];
  end

  // Read data is gated by the enable so AD_OUT is zero whenever not driving.
  assign AD_OUT = r_ad_oe ? r_rd_data : '0;
  assign AD_OE  = r_ad_oe;
  assign READY  = r_ready;
  assign CS     = r_cs;
  assign ERR    = r_err;

`ifdef ACCESS_CNT_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;

  // Completed-access counters; they wrap naturally at 16 bits.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else begin
      if (w_mem_re) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_mem_we) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign RD_CNT = r_rd_cnt;
  assign WR_CNT = r_wr_cnt;
`else
  // No access counters in this build.
`endif

endmodule

// File: tb/tb_mux_bus_slave.sv
// Directed bench for mux_bus_slave: three instances (default memory slave,
// IO slave with no wait states, memory slave with three wait states).
`timescale 1ns/1ps
module tb_mux_bus_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       ale [3];
  logic       iom [3];
  logic       rd_n[3];
  logic       wr_n[3];
  logic [7:0] ad_in[3];
  logic [11:0] a_in[3];
  logic [7:0] ad_out[3];
  logic       ad_oe[3];
  logic       ready[3];
  logic       cs  [3];
  logic       err [3];
`ifdef ACCESS_CNT_EN
  logic [15:0] rd_cnt[3];
  logic [15:0] wr_cnt[3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux_bus_slave u_mem (
    .CLK(clk), .RESET(rst_n), .ALE(ale[0]), .IOM(iom[0]), .RD(rd_n[0]), .WR(wr_n[0]),
    .AD_IN(ad_in[0]), .A_IN(a_in[0]), .AD_OUT(ad_out[0]), .AD_OE(ad_oe[0]),
    .READY(ready[0]), .CS(cs[0]), .ERR(err[0])
`ifdef ACCESS_CNT_EN
    , .RD_CNT(rd_cnt[0]), .WR_CNT(wr_cnt[0])
`endif
  );

  mux_bus_slave #(.IO_SPACE(1), .WAIT_STATES(0)) u_io (
    .CLK(clk), .RESET(rst_n), .ALE(ale[1]), .IOM(iom[1]), .RD(rd_n[1]), .WR(wr_n[1]),
    .AD_IN(ad_in[1]), .A_IN(a_in[1]), .AD_OUT(ad_out[1]), .AD_OE(ad_oe[1]),
    .READY(ready[1]), .CS(cs[1]), .ERR(err[1])
`ifdef ACCESS_CNT_EN
    , .RD_CNT(rd_cnt[1]), .WR_CNT(wr_cnt[1])
`endif
  );

  mux_bus_slave #(.WAIT_STATES(3)) u_ws3 (
    .CLK(clk), .RESET(rst_n), .ALE(ale[2]), .IOM(iom[2]), .RD(rd_n[2]), .WR(wr_n[2]),
    .AD_IN(ad_in[2]), .A_IN(a_in[2]), .AD_OUT(ad_out[2]), .AD_OE(ad_oe[2]),
    .READY(ready[2]), .CS(cs[2]), .ERR(err[2])
`ifdef ACCESS_CNT_EN
    , .RD_CNT(rd_cnt[2]), .WR_CNT(wr_cnt[2])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Address phase: one ALE cycle, then check the registered decode.
  task automatic addr_phase(input int k, input logic io, input logic [19:0] addr);
    @(negedge clk);
    ale[k]   = 1'b1;
    iom[k]   = io;
    ad_in[k] = addr[7:0];
    a_in[k]  = addr[19:8];
    @(negedge clk);
    ale[k]   = 1'b0;
  endtask

  // Full bus cycle with the strobe held for ws+4 clocks, then released.
  task automatic xfer(input int k, input string tag, input logic io, input logic [19:0] addr,
                      input logic is_rd, input logic [7:0] wdata, input int ws,
                      input logic hit, input logic [7:0] rdata);
    int         lows;
    int         lat;
    int         oe_cnt;
    logic [7:0] last_out;
    logic       last_oe;
    addr_phase(k, io, addr);
    check($sformatf("%s.cs", tag), 32'(cs[k]), 32'(hit));
    ad_in[k] = is_rd ? 8'h00 : wdata;
    if (is_rd) rd_n[k] = 1'b0;
    else       wr_n[k] = 1'b0;
    lows = 0; lat = -1; oe_cnt = 0; last_out = 8'h00; last_oe = 1'b0;
    for (int i = 1; i <= ws + 4; i++) begin
      @(negedge clk);
      if (!ready[k]) lows++;
      if (ad_oe[k]) begin
        oe_cnt++;
        if (lat < 0) lat = i - 1;
      end
      last_out = ad_out[k];
      last_oe  = ad_oe[k];
    end
    check($sformatf("%s.ready_lows", tag), 32'(lows), hit ? 32'(ws) : 32'd0);
    if (hit && is_rd) begin
      check($sformatf("%s.latency", tag), 32'(lat), 32'(ws + 1));
      check($sformatf("%s.oe_cycles", tag), 32'(oe_cnt), 32'd3);
      check($sformatf("%s.oe_held", tag), 32'(last_oe), 32'd1);
      check($sformatf("%s.rdata", tag), 32'(last_out), 32'(rdata));
    end else begin
      check($sformatf("%s.no_oe", tag), 32'(oe_cnt), 32'd0);
    end
    rd_n[k] = 1'b1;
    wr_n[k] = 1'b1;
    @(negedge clk);
    check($sformatf("%s.end_oe", tag), 32'(ad_oe[k]), 32'd0);
    check($sformatf("%s.end_cs", tag), 32'(cs[k]), 32'd0);
    check($sformatf("%s.end_ready", tag), 32'(ready[k]), 32'd1);
    $display("xfer %s u%0d %s %s addr=%05h data=%02h", tag, k, io ? "IO" : "MEM",
             is_rd ? "RD" : "WR", addr, is_rd ? last_out : wdata);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ale[k] = 1'b0; iom[k] = 1'b0; rd_n[k] = 1'b1; wr_n[k] = 1'b1;
      ad_in[k] = 8'h00; a_in[k] = 12'h000;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d.ready", k), 32'(ready[k]), 32'd1);
      check($sformatf("rst%0d.oe", k), 32'(ad_oe[k]), 32'd0);
      check($sformatf("rst%0d.cs", k), 32'(cs[k]), 32'd0);
      check($sformatf("rst%0d.err", k), 32'(err[k]), 32'd0);
      check($sformatf("rst%0d.ad_out", k), 32'(ad_out[k]), 32'd0);
    end
    $display("reset released");
    rst_n = 1'b1;
    @(negedge clk);

    // Default slave: window 0x00000..0x000FF, memory space, 2 wait states.
    xfer(0, "w00",    1'b0, 20'h00000, 1'b0, 8'h5A, 2, 1'b1, 8'h00);
    xfer(0, "w10",    1'b0, 20'h00010, 1'b0, 8'hA5, 2, 1'b1, 8'h00);
    xfer(0, "r10",    1'b0, 20'h00010, 1'b1, 8'h00, 2, 1'b1, 8'hA5);
    xfer(0, "wFF",    1'b0, 20'h000FF, 1'b0, 8'hC3, 2, 1'b1, 8'h00);
    xfer(0, "rFF",    1'b0, 20'h000FF, 1'b1, 8'h00, 2, 1'b1, 8'hC3);
    xfer(0, "r100",   1'b0, 20'h00100, 1'b1, 8'h00, 2, 1'b0, 8'h00);
    xfer(0, "w200",   1'b0, 20'h00200, 1'b0, 8'h77, 2, 1'b0, 8'h00);
    xfer(0, "wio10",  1'b1, 20'h00010, 1'b0, 8'h66, 2, 1'b0, 8'h00);
    xfer(0, "r00",    1'b0, 20'h00000, 1'b1, 8'h00, 2, 1'b1, 8'h5A);
    xfer(0, "r10b",   1'b0, 20'h00010, 1'b1, 8'h00, 2, 1'b1, 8'hA5);

    // Both strobes low in IDLE: sticky error, no access.
    addr_phase(0, 1'b0, 20'h00010);
    check("dbl.cs", 32'(cs[0]), 32'd1);
    ad_in[0] = 8'hFF; rd_n[0] = 1'b0; wr_n[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("dbl.err%0d", i), 32'(err[0]), 32'd1);
      check($sformatf("dbl.oe%0d", i), 32'(ad_oe[0]), 32'd0);
      check($sformatf("dbl.ready%0d", i), 32'(ready[0]), 32'd1);
    end
    rd_n[0] = 1'b1; wr_n[0] = 1'b1;
    @(negedge clk);
    check("dbl.cs_after", 32'(cs[0]), 32'd0);
    $display("double strobe on u0 addr=00010");
    xfer(0, "r10c", 1'b0, 20'h00010, 1'b1, 8'h00, 2, 1'b1, 8'hA5);
    check("dbl.err_sticky", 32'(err[0]), 32'd1);

    // IO slave, zero wait states.
    xfer(1, "iow5",  1'b1, 20'h00005, 1'b0, 8'h3C, 0, 1'b1, 8'h00);
    xfer(1, "memr5", 1'b0, 20'h00005, 1'b1, 8'h00, 0, 1'b0, 8'h00);
    xfer(1, "ior5",  1'b1, 20'h00005, 1'b1, 8'h00, 0, 1'b1, 8'h3C);

    // Three wait states, then a write aborted after one wait cycle.
    xfer(2, "w20", 1'b0, 20'h00020, 1'b0, 8'h11, 3, 1'b1, 8'h00);
    addr_phase(2, 1'b0, 20'h00020);
    check("abort.cs", 32'(cs[2]), 32'd1);
    ad_in[2] = 8'h99; wr_n[2] = 1'b0;
    check("abort.err_before", 32'(err[2]), 32'd0);
    @(negedge clk);
    check("abort.ready_wait", 32'(ready[2]), 32'd0);
    wr_n[2] = 1'b1;
    @(negedge clk);
    check("abort.ready", 32'(ready[2]), 32'd1);
    check("abort.err", 32'(err[2]), 32'd1);
    check("abort.oe", 32'(ad_oe[2]), 32'd0);
    $display("abort on u2 addr=00020");
`ifdef ACCESS_CNT_EN
    check("abort.wr_cnt", 32'(wr_cnt[2]), 32'd1);
`endif
    xfer(2, "r20", 1'b0, 20'h00020, 1'b1, 8'h00, 3, 1'b1, 8'h11);

    // Reset pulsed during the WAIT of a read.
    addr_phase(0, 1'b0, 20'h00010);
    rd_n[0] = 1'b0;
    @(negedge clk);
    check("rstw.ready_wait", 32'(ready[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstw.ready", 32'(ready[0]), 32'd1);
    check("rstw.oe", 32'(ad_oe[0]), 32'd0);
    check("rstw.cs", 32'(cs[0]), 32'd0);
    check("rstw.err", 32'(err[0]), 32'd0);
    rd_n[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset pulse during wait on u0");
`ifdef ACCESS_CNT_EN
    check("rstw.rd_cnt0", 32'(rd_cnt[0]), 32'd0);
`endif
    xfer(0, "r10d", 1'b0, 20'h00010, 1'b1, 8'h00, 2, 1'b1, 8'hA5);
`ifdef ACCESS_CNT_EN
    check("rstw.rd_cnt1", 32'(rd_cnt[0]), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
